// File: rtl/bram_b0_loader_pkg.sv
// Shared constants and types for the BRAM0 host loader and its accessor.
// Default geometry, FSM state encoding and packing helpers.
package bram_b0_loader_pkg;

    localparam int unsigned DEF_CNT_BIT       = 31;
    localparam int unsigned DEF_DWIDTH        = 32;
    localparam int unsigned DEF_AWIDTH        = 8;
    localparam int unsigned DEF_MEM_SIZE      = 256;
    localparam int unsigned DEF_IN_DATA_WIDTH = 8;

    localparam int unsigned BYTES_PER_WORD = DEF_DWIDTH / DEF_IN_DATA_WIDTH;
    localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bram_b0_loader_if.sv
// Byte-stream input and BRAM0 write port of the loader.
// master = loader side, slave = host/BRAM side.
interface bram_b0_loader_if
    import bram_b0_loader_pkg::*;
#(
    parameter int unsigned DWIDTH        = DEF_DWIDTH,
    parameter int unsigned AWIDTH        = DEF_AWIDTH,
    parameter int unsigned IN_DATA_WIDTH = DEF_IN_DATA_WIDTH
);
    logic                     s_valid_i;
    logic [IN_DATA_WIDTH-1:0] s_data_i;
    logic                     s_ready_o;
    logic [AWIDTH-1:0]        addr_b0_o;
    logic                     ce_b0_o;
    logic                     we_b0_o;
    logic [DWIDTH-1:0]        d_b0_o;

    modport master (
        input  s_valid_i, s_data_i,
        output s_ready_o, addr_b0_o, ce_b0_o, we_b0_o, d_b0_o
    );

    modport slave (
        output s_valid_i, s_data_i,
        input  s_ready_o, addr_b0_o, ce_b0_o, we_b0_o, d_b0_o
    );
endinterface

// File: rtl/bram_b0_loader_byte_word_packer.sv
// Packs accepted bytes into words, lane 0 first. The completing byte is
// bypassed straight into the top lane so a word is emitted on its accept edge.
module byte_word_packer
    import bram_b0_loader_pkg::*;
#(
    parameter int unsigned DWIDTH        = DEF_DWIDTH,
    parameter int unsigned IN_DATA_WIDTH = DEF_IN_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     i_clear,
    input  logic                     i_valid,
    input  logic [IN_DATA_WIDTH-1:0] i_data,
    output logic                     o_word_valid_c,
    output logic [DWIDTH-1:0]        o_word_c
);
    localparam int unsigned BPW   = DWIDTH / IN_DATA_WIDTH;
    localparam int unsigned CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned LOW_W = DWIDTH - IN_DATA_WIDTH;

    logic [CNT_W-1:0] r_cnt;
    logic [LOW_W-1:0] r_lanes;
    logic             w_last;

    assign w_last         = (r_cnt == CNT_W'(BPW - 1));
    assign o_word_valid_c = i_valid && w_last;
    assign o_word_c       = {i_data, r_lanes};

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_cnt   <= '0;
            r_lanes <= '0;
        end else if (i_valid) begin
            for (int k = 0; k < int'(BPW) - 1; k++) begin
                if (r_cnt == CNT_W'(k))
                    r_lanes[k*IN_DATA_WIDTH +: IN_DATA_WIDTH] <= i_data;
            end
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/bram_b0_loader.sv
// Host-side BRAM0 filler: packs a byte stream into words and writes them to
// sequential addresses from 0, then pulses done_o.
module bram_b0_loader
    import bram_b0_loader_pkg::*;
#(
    parameter int unsigned CNT_BIT       = DEF_CNT_BIT,
    parameter int unsigned DWIDTH        = DEF_DWIDTH,
    parameter int unsigned AWIDTH        = DEF_AWIDTH,
    parameter int unsigned MEM_SIZE      = DEF_MEM_SIZE,
    parameter int unsigned IN_DATA_WIDTH = DEF_IN_DATA_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_load_i,
    input  logic [CNT_BIT-1:0] load_count_i,
    bram_b0_loader_if.master   bus,
    output logic               idle_o,
    output logic               load_o,
    output logic               done_o,
    output logic               error_o
);
    state_t             r_state;
    logic               r_error;
    logic [CNT_BIT-1:0] r_eff_cnt;
    logic [CNT_BIT-1:0] r_word_cnt;

    logic               w_accept;
    logic               w_start;
    logic               w_over;
    logic               w_word_valid;
    logic [DWIDTH-1:0]  w_word;

    assign idle_o        = (r_state == S_IDLE);
    assign load_o        = (r_state == S_LOAD);
    assign done_o        = (r_state == S_DONE);
    assign error_o       = r_error;
    assign bus.s_ready_o = (r_state == S_LOAD);

    assign w_accept = bus.s_valid_i && bus.s_ready_o;
    assign w_start  = idle_o && start_load_i;
    assign w_over   = (load_count_i > CNT_BIT'(MEM_SIZE));

    byte_word_packer #(
        .DWIDTH        (DWIDTH),
        .IN_DATA_WIDTH (IN_DATA_WIDTH)
    ) u_packer (
        .clk            (clk),
        .i_clear        (reset || w_start),
        .i_valid        (w_accept),
        .i_data         (bus.s_data_i),
        .o_word_valid_c (w_word_valid),
        .o_word_c       (w_word)
    );

    // FSM, clamp and BRAM port registers; ce/we pulse only on a completed word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_error       <= 1'b0;
            r_eff_cnt     <= '0;
            r_word_cnt    <= '0;
            bus.addr_b0_o <= '0;
            bus.ce_b0_o   <= 1'b0;
            bus.we_b0_o   <= 1'b0;
            bus.d_b0_o    <= '0;
        end else begin
            bus.ce_b0_o <= 1'b0;
            bus.we_b0_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_load_i) begin
                        r_error    <= w_over;
                        r_eff_cnt  <= w_over ? CNT_BIT'(MEM_SIZE) : load_count_i;
                        r_word_cnt <= '0;
                        r_state    <= (load_count_i == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_word_valid) begin
                        bus.ce_b0_o   <= 1'b1;
                        bus.we_b0_o   <= 1'b1;
                        bus.d_b0_o    <= w_word;
                        bus.addr_b0_o <= AWIDTH'(r_word_cnt);
                        r_word_cnt    <= r_word_cnt + CNT_BIT'(1);
                        if (r_word_cnt + CNT_BIT'(1) == r_eff_cnt)
                            r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/bram_b0_loader.md
Name: bram_b0_loader

Overview:
Host-side writer that fills BRAM0 before BRAM_accessor reads it. It accepts a byte stream on a valid/ready handshake and packs every IN_DATA_WIDTH-wide byte into DWIDTH words, least-significant lane first. It writes the words to sequential BRAM0 addresses starting at 0, then pulses done_o. The data format matches what the accessor consumes from q_b0_i: 4 x 8-bit lanes per 32-bit word.

Parameters:
CNT_BIT, 31, width of load_count_i (count is in words)
DWIDTH, 32, BRAM0 data width
AWIDTH, 8, BRAM0 address width
MEM_SIZE, 256, BRAM0 depth in words; maximum load count
IN_DATA_WIDTH, 8, input byte width; DWIDTH must be an integer multiple of it

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous reset, active-high
start_load_i  in  1  one-cycle start pulse; sampled only in IDLE
load_count_i  in  CNT_BIT  number of words to load; sampled with start_load_i
s_valid_i  in  1  input byte valid
s_data_i  in  IN_DATA_WIDTH  input byte
s_ready_o  out  1  loader can accept a byte
idle_o  out  1  FSM in IDLE
load_o  out  1  FSM in LOAD
done_o  out  1  one-cycle completion pulse
error_o  out  1  load_count_i exceeded MEM_SIZE; sticky until next accepted start
addr_b0_o  out  AWIDTH  BRAM0 address
ce_b0_o  out  1  BRAM0 chip enable
we_b0_o  out  1  BRAM0 write enable
d_b0_o  out  DWIDTH  BRAM0 write data

Behaviour:
- Reset (synchronous, active-high, any state):
  - FSM goes to IDLE. idle_o=1; load_o, done_o, error_o, s_ready_o, ce_b0_o and we_b0_o are 0; addr_b0_o=0; d_b0_o=0.
  - Partial word, byte counter and word counter are cleared. No write is issued for the partial word.
- FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on start_load_i=1 with count>0.
  - IDLE -> DONE on start_load_i=1 with count=0.
  - LOAD -> DONE on acceptance of the last byte of the last word.
  - DONE -> IDLE unconditionally after 1 cycle.
- start_load_i outside IDLE is ignored.
- Count clamp: if load_count_i > MEM_SIZE, the effective count is MEM_SIZE and error_o is set. error_o clears on the next accepted start.
- Handshake:
  - A byte is accepted when s_valid_i & s_ready_o at a rising edge.
  - s_ready_o=1 only in LOAD (registered state decode).
  - s_data_i is ignored when not accepted. Bubbles in s_valid_i are allowed.
- Packing:
  - Byte k (k = 0 .. BYTES_PER_WORD-1) of a word goes to bits [k*IN_DATA_WIDTH +: IN_DATA_WIDTH].
  - BYTES_PER_WORD = DWIDTH/IN_DATA_WIDTH.
- Write timing:
  - On the edge accepting byte BYTES_PER_WORD-1, the full word is registered into d_b0_o, and ce_b0_o=we_b0_o=1 for exactly the following cycle.
  - addr_b0_o = word index, which starts at 0 and increments by 1 after each write.
  - The packer keeps accepting bytes during the write cycle, giving a throughput of 1 byte/cycle with no stall.
- Final word: its write cycle coincides with DONE, so done_o and the last we_b0_o are high in the same cycle.
- count=0: done_o is high the cycle after start; no write occurs.
- Address never wraps: the clamp guarantees the last address is MEM_SIZE-1 (255).
- ce_b0_o/we_b0_o are 0 in every cycle without a write. addr_b0_o and d_b0_o hold their last values between writes.
- Counters: the word counter is CNT_BIT wide, compared against the effective count; the byte counter is clog2(BYTES_PER_WORD) wide.

Decomposition:
- Shared package (alongside the accessor's constants): FSM state localparams S_IDLE/S_LOAD/S_DONE, BYTES_PER_WORD, BYTE_CNT_W = clog2(BYTES_PER_WORD).
- One natural sub-module: byte_word_packer. It holds the byte counter and shift/lane register, emits word_valid plus word, and has a clear input driven by start/reset.
- The top level holds the FSM, word counter, clamp/error logic and BRAM port registers.

Test Plan:
- Reset held 4 cycles, then released -> idle_o=1; s_ready_o, ce_b0_o, we_b0_o, done_o, error_o = 0; addr_b0_o=0.
- start with count=2, bytes 0x01..0x08 streamed back-to-back -> write addr 0 d=32'h04030201, then addr 1 d=32'h08070605; done_o coincides with the second write; idle_o=1 on the next cycle.
- Same as previous with s_valid_i dropped every other cycle -> identical writes and data, each delayed by the bubbles; no write on idle cycles.
- start with count=0 -> done_o=1 exactly one cycle later; ce_b0_o never asserted.
- start with count=300, 1024 bytes of 0x01 -> error_o=1; 256 writes of 32'h01010101 at addresses 0..255; done_o with the write to 255; s_ready_o=0 afterwards.
- start with count=4, 6 bytes sent, reset pulsed, start_load_i pulsed again mid-load before the reset -> only addr 0 written; the mid-load start is ignored; after reset idle_o=1 and no partial-word write.
